// File: rtl/lza_shift_encoder.sv
// lza_shift_encoder
//   Two-stage leading-zero encoder for the LZA indicator string of an FP adder.
//   S1 splits f into seven 8-bit groups (group 0 = bits 55:48, group 6 = bits
//   7:0) and registers a nonzero flag plus a 3-bit in-group leading-zero count
//   for each group. S2 picks the most significant nonzero group and registers
//   the final count. The stages are joined by a valid/ready handshake, so there
//   is one result per cycle when the consumer never stalls.
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : f is valid this cycle
//   in_ready   : block accepts f this cycle (forced low while rst_n is low)
//   f[55:0]    : indicator string, bit 55 is the MSB
//   out_valid  : lz_cnt / all_zero hold a result
//   out_ready  : consumer takes the result this cycle
//   lz_cnt[5:0]: leading zeros of f counted from bit 55, range 0..56
//   all_zero   : f was all zeros (lz_cnt is then 56)
module lza_shift_encoder #(
  parameter int W   = 56,  // only 56 is supported
  parameter int GRP = 8    // group width; W/GRP groups
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] f,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [5:0]   lz_cnt,
  output logic         all_zero
);

  localparam int NG = W / GRP;

  // Leading-zero count inside one 8-bit group. An all-zero group returns 0;
  // its nonzero flag keeps it from ever being selected.
  function automatic logic [2:0] grp_lzc(input logic [7:0] b);
    logic [2:0] c;
    casez (b)
      8'b1???????: c = 3'd0;
      8'b01??????: c = 3'd1;
      8'b001?????: c = 3'd2;
      8'b0001????: c = 3'd3;
      8'b00001???: c = 3'd4;
      8'b000001??: c = 3'd5;
      8'b0000001?: c = 3'd6;
      8'b00000001: c = 3'd7;
      default:     c = 3'd0;
    endcase
    return c;
  endfunction

  // Final encode: {all_zero, lz_cnt}. Groups are scanned from the least
  // significant upward so that the lowest-index nonzero group is the last
  // to write the result, giving priority to the most significant group.
  function automatic logic [6:0] grp_select(input logic [NG-1:0]   nz,
                                             input logic [3*NG-1:0] cnt);
    logic [6:0] r;
    r = {1'b1, 6'd56};
    for (int g = NG - 1; g >= 0; g--) begin
      if (nz[g]) begin
        r = {1'b0, 6'(GRP * g) + {3'b000, cnt[3*g +: 3]}};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Stage 1 state
  logic              s1_valid_r;
  logic [NG-1:0]     grp_nz_r;
  logic [3*NG-1:0]   grp_cnt_r;

  // Stage 2 state (drives the outputs directly)
  logic              out_valid_r;
  logic [5:0]        lz_cnt_r;
  logic              all_zero_r;

  // Combinational helpers
  logic              s2_ready_s;
  logic              s1_ready_s;
  logic [NG-1:0]     grp_nz_s;
  logic [3*NG-1:0]   grp_cnt_s;
  logic [6:0]        sel_s;

  // Handshake: a stage may load when it is empty or its contents leave this edge.
  always_comb begin
    s2_ready_s = !out_valid_r || out_ready;
    s1_ready_s = !s1_valid_r || s2_ready_s;
    in_ready   = s1_ready_s && rst_n;
  end

  // Per-group nonzero flag and in-group leading-zero count from the raw input.
  always_comb begin
    grp_nz_s  = '0;
    grp_cnt_s = '0;
    for (int g = 0; g < NG; g++) begin
      grp_nz_s[g]         = |f[W-1-GRP*g -: GRP];
      grp_cnt_s[3*g +: 3] = grp_lzc(f[W-1-GRP*g -: GRP]);
    end
  end

  // Group priority selection on the registered stage-1 data.
  always_comb begin
    sel_s = grp_select(grp_nz_r, grp_cnt_r);
  end

  // Stage 1 register: loads whenever it can move, keeping data on a stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      grp_nz_r   <= '0;
      grp_cnt_r  <= '0;
    end else if (s1_ready_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        grp_nz_r  <= grp_nz_s;
        grp_cnt_r <= grp_cnt_s;
      end
    end
  end

  // Stage 2 register: result held stable while the consumer stalls; the data
  // fields keep their last value when the stage drains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      lz_cnt_r    <= 6'd0;
      all_zero_r  <= 1'b0;
    end else if (s2_ready_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        lz_cnt_r   <= sel_s[5:0];
        all_zero_r <= sel_s[6];
      end
    end
  end

  assign out_valid = out_valid_r;
  assign lz_cnt    = lz_cnt_r;
  assign all_zero  = all_zero_r;

endmodule

// File: tb/tb_lza_shift_encoder.sv
module tb_lza_shift_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [55:0] f;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  lz_cnt;
  logic        all_zero;

  int tests  = 0;
  int failed = 0;

  logic [6:0] sbq[$];      // expected {all_zero, lz_cnt} in acceptance order
  logic       hold_chk = 1'b0;
  logic [5:0] hold_lz;
  logic       hold_az;

  typedef struct {
    logic [55:0] f;
    logic [5:0]  lz;
    logic        az;
  } vec_t;

  vec_t tbl[11];

  lza_shift_encoder #(.W(56), .GRP(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .f(f), .out_valid(out_valid), .out_ready(out_ready),
    .lz_cnt(lz_cnt), .all_zero(all_zero)
  );

  always #5 clk = ~clk;

  // Reference: walk down from bit 55 until a one is found.
  function automatic logic [6:0] ref_lz(input logic [55:0] v);
    int k;
    k = 0;
    while (k < 56 && v[55-k] == 1'b0) k++;
    return {(k == 56), 6'(k)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive at the negedge, check and score, then advance.
  task automatic cycle(input logic v, input logic [55:0] fv, input logic ordy);
    logic [6:0] e;
    in_valid  = v;
    f         = fv;
    out_ready = ordy;
    #1;
    if (!rst_n) chk("in_ready_in_reset", in_ready, 0);
    if (hold_chk) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_lz", lz_cnt, hold_lz);
      chk("hold_az", all_zero, hold_az);
    end
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_output: got lz_cnt %0d with no pending result", lz_cnt);
      end else begin
        e = sbq.pop_front();
        chk("sb_lz", lz_cnt, e[5:0]);
        chk("sb_az", all_zero, e[6]);
      end
    end
    if (rst_n && in_valid && in_ready) sbq.push_back(ref_lz(f));
    if (!rst_n) sbq.delete();
    hold_chk = rst_n && out_valid && !out_ready;
    hold_lz  = lz_cnt;
    hold_az  = all_zero;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [55:0] sf[4];
    logic [5:0]  se[4];
    logic [63:0] r;
    logic [6:0]  ex;

    tbl[0]  = '{56'h80_0000_0000_0000, 6'd0,  1'b0};
    tbl[1]  = '{56'h00_0000_0100_0000, 6'd31, 1'b0};
    tbl[2]  = '{56'h00_0000_0000_0001, 6'd55, 1'b0};
    tbl[3]  = '{56'hFF_FFFF_FFFF_FFFF, 6'd0,  1'b0};
    tbl[4]  = '{56'h00_0000_0000_0000, 6'd56, 1'b1};
    tbl[5]  = '{56'h00_8000_0000_0000, 6'd8,  1'b0};
    tbl[6]  = '{56'h00_0100_0000_0000, 6'd15, 1'b0};
    tbl[7]  = '{56'h01_0000_0000_0000, 6'd7,  1'b0};
    tbl[8]  = '{56'h00_0000_0000_0100, 6'd47, 1'b0};
    tbl[9]  = '{56'h00_0000_0000_0080, 6'd48, 1'b0};
    tbl[10] = '{56'h00_0000_3FFF_0000, 6'd26, 1'b0};

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; f = 56'd0; out_ready = 1'b0;
    @(negedge clk);
    cycle(1'b1, 56'h1, 1'b0);
    cycle(1'b0, 56'h0, 1'b0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_lz_cnt", lz_cnt, 0);
    chk("rst_all_zero", all_zero, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", in_ready, 1);
    chk("idle_after_rst", out_valid, 0);
    @(negedge clk);

    // Table vectors: two-cycle latency and the encoded value
    for (int i = 0; i < 11; i++) begin
      cycle(1'b1, tbl[i].f, 1'b1);
      in_valid = 1'b0; out_ready = 1'b1; #1;
      chk("latency_not_early", out_valid, 0);
      cycle(1'b0, 56'h0, 1'b1);
      in_valid = 1'b0; out_ready = 1'b1; #1;
      chk("vec_valid", out_valid, 1);
      chk("vec_lz", lz_cnt, tbl[i].lz);
      chk("vec_az", all_zero, tbl[i].az);
      cycle(1'b0, 56'h0, 1'b1);
    end

    // Back-to-back stream: results on consecutive cycles
    sf[0] = 56'h80_0000_0000_0000; se[0] = 6'd0;
    sf[1] = 56'h00_8000_0000_0000; se[1] = 6'd8;
    sf[2] = 56'h00_0100_0000_0000; se[2] = 6'd15;
    sf[3] = 56'h00_0000_0000_0000; se[3] = 6'd56;
    for (int k = 0; k < 6; k++) begin
      in_valid = (k < 4); f = (k < 4) ? sf[k%4] : 56'h0; out_ready = 1'b1; #1;
      if (k >= 2) begin
        chk("stream_valid", out_valid, 1);
        chk("stream_lz", lz_cnt, se[k-2]);
      end
      cycle(k < 4, (k < 4) ? sf[k%4] : 56'h0, 1'b1);
    end
    for (int k = 0; k < 2; k++) cycle(1'b0, 56'h0, 1'b1);

    // Backpressure: two accepts, then blocked with the first result held
    cycle(1'b1, 56'h00_0000_0000_0200, 1'b0);
    cycle(1'b1, 56'h00_0040_0000_0000, 1'b0);
    in_valid = 1'b1; f = 56'h00_0000_0800_0000; out_ready = 1'b0; #1;
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_first_valid", out_valid, 1);
    chk("bp_first_lz", lz_cnt, 6'd46);
    cycle(1'b1, 56'h00_0000_0800_0000, 1'b0);
    cycle(1'b1, 56'h00_0000_0800_0000, 1'b0);
    cycle(1'b1, 56'h00_0000_0800_0000, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b0, 56'h0, 1'b1);
    chk("bp_drained", sbq.size(), 0);

    // Reset with both stages full discards everything
    cycle(1'b1, 56'h00_0000_0000_0001, 1'b0);
    cycle(1'b1, 56'h00_0000_0000_0002, 1'b0);
    rst_n = 1'b0;
    cycle(1'b1, 56'h00_0000_0000_0004, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 56'h0, 1'b1);
      chk("no_stale_output", out_valid, 0);
    end

    // Full throughput with no backpressure
    for (int k = 0; k < 40; k++) begin
      r = {$urandom, $urandom};
      in_valid = 1'b1; f = r[55:0] >> $urandom_range(0, 56); out_ready = 1'b1; #1;
      chk("tput_in_ready", in_ready, 1);
      if (k >= 2) chk("tput_out_valid", out_valid, 1);
      cycle(1'b1, f, 1'b1);
    end
    for (int k = 0; k < 3; k++) cycle(1'b0, 56'h0, 1'b1);

    // Random traffic against the reference model
    for (int k = 0; k < 600; k++) begin
      r = {$urandom, $urandom};
      cycle($urandom_range(0, 9) < 7, r[55:0] >> $urandom_range(0, 56),
            $urandom_range(0, 9) < 6);
      if (out_valid) begin
        ex = {1'b0, lz_cnt};
        chk("lz_range", (ex > 7'd56), 0);
      end
    end
    for (int k = 0; k < 6; k++) cycle(1'b0, 56'h0, 1'b1);
    chk("final_drained", sbq.size(), 0);
    chk("final_idle", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
